// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the CNN image loader slice.
// Optional feature macro: CNN_LOADER_RELU_EN (clamps negative pixels to zero on store).
package cnn_pkg;

    localparam int IMG_W = 32'sd28;
    localparam int IMG_H = 32'sd28;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int PIX_W = 32'sd9;

    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef logic [3:0]              class_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/cnn_latency_timer.sv
// Loadable down-counter that times the CNN core latency.
// 'start' loads CNN_LAT; 'expired' is a registered one-cycle pulse issued on the
// edge where the count reaches zero, so a start at edge T gives expired high
// during the cycle after edge T+CNN_LAT.
module cnn_latency_timer
    import cnn_pkg::*;
#(
    parameter int CNN_LAT = 32'sd16
)(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic expired
);

    localparam int            CW       = $clog2(CNN_LAT + 32'sd1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(CNN_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

    logic [CW-1:0] cnt_r;
    logic          run_r;
    logic          expired_r;

    // Count down from the loaded latency and flag the final step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= CNT_ZERO;
            run_r     <= 1'b0;
            expired_r <= 1'b0;
        end else if (start) begin
            cnt_r     <= LOAD_VAL;
            run_r     <= 1'b1;
            expired_r <= 1'b0;
        end else if (run_r) begin
            if (cnt_r == CNT_ONE) begin
                cnt_r     <= CNT_ZERO;
                run_r     <= 1'b0;
                expired_r <= 1'b1;
            end else begin
                cnt_r     <= cnt_r - CNT_ONE;
                run_r     <= 1'b1;
                expired_r <= 1'b0;
            end
        end else begin
            cnt_r     <= cnt_r;
            run_r     <= 1'b0;
            expired_r <= 1'b0;
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/cnn_image_loader.sv
// Streams a row-major pixel frame over valid/ready into the parallel image array
// feeding the CNN core, waits the core latency, then offers the predicted class
// on a result handshake. Frame-length errors pulse err_len for one cycle.
// Optional feature macro: CNN_LOADER_RELU_EN (negative pixels stored as zero).
module cnn_image_loader
    import cnn_pkg::*;
#(
    parameter int IMG_W   = 32'sd28,
    parameter int IMG_H   = 32'sd28,
    parameter int PIX_W   = 32'sd9,
    parameter int CNN_LAT = 32'sd16
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [PIX_W-1:0] s_data,
    input  logic                    s_last,
    output logic signed [PIX_W-1:0] image_out [0:IMG_W*IMG_H-1],
    input  logic [3:0]              cnn_predict,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [3:0]              res_class,
    output logic                    err_len
);

    localparam int               NPIX     = IMG_W * IMG_H;
    localparam int               IDX_W    = $clog2(NPIX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPIX - 32'sd1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(32'd0);

    ldr_state_t              state_r;
    ldr_state_t              state_s;
    logic [IDX_W-1:0]        idx_r;
    logic                    s_ready_r;
    logic                    res_valid_r;
    class_t                  res_class_r;
    logic                    err_len_r;
    logic signed [PIX_W-1:0] image_r [0:NPIX-1];

    logic                    accept_s;
    logic                    at_last_s;
    logic                    timer_start_s;
    logic                    timer_expired_s;
    logic signed [PIX_W-1:0] pix_s;

    // Value written into the image array for an accepted pixel.
    function automatic logic signed [PIX_W-1:0] store_value(input logic signed [PIX_W-1:0] d);
`ifdef CNN_LOADER_RELU_EN
        if (d[PIX_W-1]) begin
            store_value = {PIX_W{1'b0}};
        end else begin
            store_value = d;
        end
`else
        store_value = d;
`endif
    endfunction

    assign accept_s      = (state_r == LOAD) && s_ready_r && s_valid;
    assign at_last_s     = (idx_r == IDX_LAST);
    assign timer_start_s = accept_s && at_last_s;
    assign pix_s         = store_value(s_data);

    cnn_latency_timer #(
        .CNN_LAT (CNN_LAT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (timer_start_s),
        .expired (timer_expired_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: a full frame moves to WAIT, the timer moves to RESULT,
    // and a consumed result returns to LOAD.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (timer_start_s) begin
                    state_s = WAIT;
                end else begin
                    state_s = LOAD;
                end
            end
            WAIT: begin
                if (timer_expired_s) begin
                    state_s = RESULT;
                end else begin
                    state_s = WAIT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_s = LOAD;
                end else begin
                    state_s = RESULT;
                end
            end
            default: begin
                state_s = LOAD;
            end
        endcase
    end

    // Pixel index: wraps to zero at frame end or on an early s_last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r <= IDX_ZERO;
        end else if (accept_s) begin
            if (at_last_s || s_last) begin
                idx_r <= IDX_ZERO;
            end else begin
                idx_r <= idx_r + IDX_ONE;
            end
        end else begin
            idx_r <= idx_r;
        end
    end

    // Registered handshake and status outputs, derived from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready_r   <= 1'b0;
            res_valid_r <= 1'b0;
            err_len_r   <= 1'b0;
        end else begin
            s_ready_r   <= (state_s == LOAD);
            res_valid_r <= (state_s == RESULT);
            err_len_r   <= accept_s && (at_last_s ? !s_last : s_last);
        end
    end

    // Capture the core's class when the latency interval ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_class_r <= 4'd0;
        end else if ((state_r == WAIT) && timer_expired_s) begin
            res_class_r <= cnn_predict;
        end else begin
            res_class_r <= res_class_r;
        end
    end

    // Image store: written only on accepted pixels, so it is frozen outside LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPIX; i++) begin
                image_r[i] <= {PIX_W{1'b0}};
            end
        end else if (accept_s) begin
            image_r[idx_r] <= pix_s;
        end else begin
            image_r <= image_r;
        end
    end

    assign image_out = image_r;
    assign s_ready   = s_ready_r;
    assign res_valid = res_valid_r;
    assign res_class = res_class_r;
    assign err_len   = err_len_r;

endmodule
